// File: rtl/red_centroid_detector.sv
// Red-object centroid over an RGB565 AXI-Stream frame, published once per frame.
// Define RED_CENTROID_HOLD_EN to keep the previous centroid on an invalid publish.
module red_centroid_detector #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned R_MIN      = 20,
    parameter int unsigned G_MAX      = 20,
    parameter int unsigned B_MAX      = 12,
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_tvalid,
    input  logic [31:0] i_tdata,
    input  logic        i_tuser,
    input  logic        i_tlast,
    output logic        o_tready,
    output logic [9:0]  o_centroid_x,
    output logic [8:0]  o_centroid_y,
    output logic        o_end_frame,
    output logic        o_red_object_valid
);

    localparam logic [9:0]  X_LAST   = 10'(IMG_WIDTH - 1);
    localparam logic [8:0]  Y_LAST   = 9'(IMG_HEIGHT - 1);
    localparam logic [4:0]  R_MIN_V  = 5'(R_MIN);
    localparam logic [5:0]  G_MAX_V  = 6'(G_MAX);
    localparam logic [4:0]  B_MAX_V  = 5'(B_MAX);
    localparam logic [18:0] MIN_CNT  = 19'(MIN_PIXELS);
    localparam logic [4:0]  DIV_LAST = 5'd27;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DIVIDE,
        S_PUBLISH
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [27:0] sum_x_q, sum_x_d;
    logic [27:0] sum_y_q, sum_y_d;
    logic [18:0] count_q, count_d;
    logic [18:0] rem_x_q, rem_x_d;
    logic [18:0] rem_y_q, rem_y_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [9:0]  cx_q, cx_d;
    logic [8:0]  cy_q, cy_d;
    logic        valid_q, valid_d;
    logic        end_frame_q, end_frame_d;

    logic        fire;
    logic        in_frame;
    logic        is_red;
    logic        frame_last;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [27:0] acc_sum_x, acc_sum_y;
    logic [18:0] acc_count;
    logic [19:0] rem_sh_x, rem_sh_y;
    logic [19:0] rem_sub_x, rem_sub_y;
    logic        take_x, take_y;
    logic        unused_bits;

    assign o_tready = i_rstn && (state_q == S_IDLE || state_q == S_ACCUM);
    assign fire     = i_tvalid && o_tready;
    // An SOF beat always lands at (0,0) with empty sums, in IDLE and as an early restart.
    assign in_frame = (state_q == S_ACCUM) || i_tuser;
    assign px       = i_tuser ? '0 : x_q;
    assign py       = i_tuser ? '0 : y_q;
    assign is_red   = (i_tdata[15:11] >= R_MIN_V) && (i_tdata[10:5] <= G_MAX_V)
                      && (i_tdata[4:0] <= B_MAX_V);

    assign acc_sum_x  = (i_tuser ? '0 : sum_x_q) + (is_red ? {18'd0, px} : 28'd0);
    assign acc_sum_y  = (i_tuser ? '0 : sum_y_q) + (is_red ? {19'd0, py} : 28'd0);
    assign acc_count  = (i_tuser ? '0 : count_q) + {18'd0, is_red};
    assign frame_last = (px == X_LAST) && (py == Y_LAST);

    // During divide the sum registers double as dividend/quotient shift registers.
    assign rem_sh_x  = {rem_x_q, sum_x_q[27]};
    assign rem_sh_y  = {rem_y_q, sum_y_q[27]};
    assign rem_sub_x = rem_sh_x - {1'b0, count_q};
    assign rem_sub_y = rem_sh_y - {1'b0, count_q};
    assign take_x    = rem_sh_x >= {1'b0, count_q};
    assign take_y    = rem_sh_y >= {1'b0, count_q};

    assign unused_bits = ^{i_tlast, i_tdata[31:16], rem_sub_x[19], rem_sub_y[19]};

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        sum_x_d     = sum_x_q;
        sum_y_d     = sum_y_q;
        count_d     = count_q;
        rem_x_d     = rem_x_q;
        rem_y_d     = rem_y_q;
        div_cnt_d   = div_cnt_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        valid_d     = valid_q;
        end_frame_d = 1'b0;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (fire && in_frame) begin
                    sum_x_d = acc_sum_x;
                    sum_y_d = acc_sum_y;
                    count_d = acc_count;
                    if (frame_last) begin
                        x_d = '0;
                        y_d = '0;
                        if (acc_count >= MIN_CNT) begin
                            state_d   = S_DIVIDE;
                            rem_x_d   = '0;
                            rem_y_d   = '0;
                            div_cnt_d = '0;
                        end else begin
                            state_d     = S_PUBLISH;
                            end_frame_d = 1'b1;
                            valid_d     = 1'b0;
`ifndef RED_CENTROID_HOLD_EN
                            cx_d        = '0;
                            cy_d        = '0;
`endif
                        end
                    end else begin
                        state_d = S_ACCUM;
                        if (px == X_LAST) begin
                            x_d = '0;
                            y_d = py + 9'd1;
                        end else begin
                            x_d = px + 10'd1;
                            y_d = py;
                        end
                    end
                end
            end
            S_DIVIDE: begin
                rem_x_d   = take_x ? rem_sub_x[18:0] : rem_sh_x[18:0];
                rem_y_d   = take_y ? rem_sub_y[18:0] : rem_sh_y[18:0];
                sum_x_d   = {sum_x_q[26:0], take_x};
                sum_y_d   = {sum_y_q[26:0], take_y};
                div_cnt_d = div_cnt_q + 5'd1;
                if (div_cnt_q == DIV_LAST) begin
                    state_d     = S_PUBLISH;
                    end_frame_d = 1'b1;
                    valid_d     = 1'b1;
                    cx_d        = sum_x_d[9:0];
                    cy_d        = sum_y_d[8:0];
                end
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            count_q     <= '0;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            div_cnt_q   <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            valid_q     <= 1'b0;
            end_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            count_q     <= count_d;
            rem_x_q     <= rem_x_d;
            rem_y_q     <= rem_y_d;
            div_cnt_q   <= div_cnt_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            valid_q     <= valid_d;
            end_frame_q <= end_frame_d;
        end
    end

    assign o_centroid_x       = cx_q;
    assign o_centroid_y       = cy_q;
    assign o_end_frame        = end_frame_q;
    assign o_red_object_valid = valid_q;

endmodule

// File: tb/tb_red_centroid_detector.sv
// Directed-plus-random bench for red_centroid_detector on a reduced 112x62 image,
// with a frame-level reference model computing the expected centroid.
module tb_red_centroid_detector;

    localparam int IMG_W = 112;
    localparam int IMG_H = 62;
    localparam int MINP  = 64;
    localparam int R_MIN = 20;
    localparam int G_MAX = 20;
    localparam int B_MAX = 12;

    logic        i_clk  = 1'b0;
    logic        i_rstn = 1'b1;
    logic        i_tvalid, i_tuser, i_tlast;
    logic [31:0] i_tdata;
    logic        o_tready, o_end_frame, o_red_object_valid;
    logic [9:0]  o_centroid_x;
    logic [8:0]  o_centroid_y;

    always #5 i_clk = ~i_clk;

    red_centroid_detector #(
        .IMG_WIDTH (IMG_W),
        .IMG_HEIGHT(IMG_H),
        .R_MIN     (R_MIN),
        .G_MAX     (G_MAX),
        .B_MAX     (B_MAX),
        .MIN_PIXELS(MINP)
    ) dut (
        .i_clk             (i_clk),
        .i_rstn            (i_rstn),
        .i_tvalid          (i_tvalid),
        .i_tdata           (i_tdata),
        .i_tuser           (i_tuser),
        .i_tlast           (i_tlast),
        .o_tready          (o_tready),
        .o_centroid_x      (o_centroid_x),
        .o_centroid_y      (o_centroid_y),
        .o_end_frame       (o_end_frame),
        .o_red_object_valid(o_red_object_valid)
    );

    int          tests  = 0;
    int          fails  = 0;
    int          pulses = 0;
    int          lat, low, p0;
    logic [15:0] img [IMG_H][IMG_W];
    logic [31:0] got_x, got_y, got_v;
    logic [31:0] exp_x = 0, exp_y = 0, exp_v = 0;

    always @(negedge i_clk) if (o_end_frame) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) img[y][x] = v;
    endtask

    task automatic fill_random();
        logic [31:0] r;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                r = $urandom();
                img[y][x] = r[15:0];
            end
        // guarantee enough red pixels so the frame always goes through the divider
        for (int x = 0; x < MINP; x++) img[0][x] = 16'hF800;
    endtask

    task automatic square(input int cx, input int cy, input int half);
        for (int y = cy - half; y <= cy + half; y++)
            for (int x = cx - half; x <= cx + half; x++) img[y][x] = 16'hF800;
    endtask

    task automatic scatter(input int n);
        int placed = 0;
        int x, y;
        while (placed < n) begin
            x = $urandom_range(0, IMG_W - 1);
            y = $urandom_range(0, IMG_H - 1);
            if (img[y][x] != 16'hF800) begin
                img[y][x] = 16'hF800;
                placed++;
            end
        end
    endtask

    // Reference: mean coordinate of red pixels, floored; invalid below MINP.
    task automatic model();
        longint      sx = 0, sy = 0, n = 0;
        logic [15:0] p;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                p = img[y][x];
                if (int'(p[15:11]) >= R_MIN && int'(p[10:5]) <= G_MAX && int'(p[4:0]) <= B_MAX) begin
                    sx += x;
                    sy += y;
                    n++;
                end
            end
        if (n >= MINP) begin
            exp_v = 1;
            exp_x = 32'(sx / n);
            exp_y = 32'(sy / n);
        end else begin
            exp_v = 0;
`ifndef RED_CENTROID_HOLD_EN
            exp_x = 0;
            exp_y = 0;
`endif
        end
    endtask

    task automatic send(input int gap_pct, input int nrows);
        logic [31:0] r;
        for (int y = 0; y < nrows; y++)
            for (int x = 0; x < IMG_W; x++) begin
                while (int'($urandom_range(0, 99)) < gap_pct) begin
                    r = $urandom();
                    i_tvalid = 1'b0;
                    i_tuser  = r[0];
                    @(posedge i_clk); #1;
                end
                r = $urandom();
                i_tvalid = 1'b1;
                i_tuser  = (x == 0 && y == 0);
                i_tlast  = r[16];
                i_tdata  = {r[31:16], img[y][x]};
                @(posedge i_clk); #1;
            end
        i_tvalid = 1'b0;
        i_tuser  = 1'b0;
    endtask

    // Starts one sample after the final beat's edge; lat counts edges until the pulse.
    task automatic wait_publish();
        lat = -1;
        low = 0;
        got_x = 'x;
        got_y = 'x;
        got_v = 'x;
        for (int i = 0; i < 100; i++) begin
            if (o_end_frame && lat < 0) begin
                lat   = i;
                got_x = 32'(o_centroid_x);
                got_y = 32'(o_centroid_y);
                got_v = 32'(o_red_object_valid);
            end
            if (!o_tready) low++;
            if (lat >= 0 && o_tready) break;
            @(posedge i_clk); #1;
        end
    endtask

    task automatic run_frame(input string tag, input int gap_pct);
        int p_start;
        model();
        p_start = pulses;
        send(gap_pct, IMG_H);
        wait_publish();
        check({tag, ".latency"}, lat, exp_v ? 28 : 0);
        check({tag, ".ready_low"}, low, exp_v ? 29 : 1);
        check({tag, ".valid"}, got_v, exp_v);
        check({tag, ".x"}, got_x, exp_x);
        check({tag, ".y"}, got_y, exp_y);
        check({tag, ".pulses"}, pulses - p_start, 1);
    endtask

    initial begin
        i_tvalid = 1'b0;
        i_tuser  = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = '0;
        #1 i_rstn = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst.tready", o_tready, 0);
        check("rst.x", o_centroid_x, 0);
        check("rst.y", o_centroid_y, 0);
        check("rst.end_frame", o_end_frame, 0);
        check("rst.valid", o_red_object_valid, 0);
        i_rstn = 1'b1;
        #1;
        check("rst.tready_after", o_tready, 1);
        @(posedge i_clk); #1;

        fill(16'h0000);
        run_frame("black", 0);

        fill(16'h0000);
        square(100, 50, 10);
        run_frame("square", 0);

        repeat (10) @(posedge i_clk);
        #1;
        check("hold.x", o_centroid_x, exp_x);
        check("hold.y", o_centroid_y, exp_y);
        check("hold.valid", o_red_object_valid, exp_v);
        check("hold.end_frame", o_end_frame, 0);

        fill(16'hF800);
        run_frame("full", 0);

        fill(16'h0000);
        scatter(MINP - 1);
        run_frame("below_min", 0);

        fill(16'h0000);
        scatter(MINP);
        run_frame("at_min", 0);

        fill_random();
        model();
        p0 = pulses;
        send(0, IMG_H);
        repeat (10) @(posedge i_clk);
        #1;
        check("div.tready", o_tready, 0);
        i_rstn = 1'b0;
        #1;
        exp_x = 0;
        exp_y = 0;
        exp_v = 0;
        check("rst_div.x", o_centroid_x, exp_x);
        check("rst_div.y", o_centroid_y, exp_y);
        check("rst_div.valid", o_red_object_valid, exp_v);
        check("rst_div.tready", o_tready, 0);
        repeat (3) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        repeat (40) @(posedge i_clk);
        #1;
        check("rst_div.no_pulse", pulses - p0, 0);

        fill_random();
        run_frame("rand_gaps", 25);

        fill(16'h0000);
        square(20, 20, 10);
        p0 = pulses;
        send(30, 40);
        check("sof.no_pulse", pulses - p0, 0);
        fill(16'h0000);
        square(100, 50, 10);
        run_frame("sof_restart", 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/red_centroid_detector.md
RED_CENTROID_DETECTOR -- requirements
Module: red_centroid_detector

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: active pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480: lines per frame.
REQ-003 SHALL have parameters R_MIN 20, G_MAX 20, B_MAX 12: RGB565 red-classification thresholds.
REQ-004 SHALL have parameter MIN_PIXELS, default 64: minimum red-pixel count for a valid object.
REQ-005 SHALL have port i_clk input 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port i_rstn input 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports i_tvalid in 1, i_tdata in 32, i_tuser in 1 (SOF), i_tlast in 1 (EOL): AXI-Stream pixel sink, RGB565 in i_tdata[15:0].
REQ-008 SHALL have port o_tready output 1: sink ready.
REQ-009 SHALL have ports o_centroid_x out 10, o_centroid_y out 9: published centroid.
REQ-010 SHALL have port o_end_frame output 1: one-cycle publish pulse.
REQ-011 SHALL have port o_red_object_valid output 1: qualifies published centroid.

Function
REQ-012 Beat accepted ("fire") iff i_tvalid && o_tready; x/y raster counters advance only on fire, x wraps at IMG_WIDTH-1, y increments on x wrap.
REQ-013 Pixel is red iff R=[15:11] >= R_MIN, G=[10:5] <= G_MAX, B=[4:0] <= B_MAX.
REQ-014 FSM states S_IDLE, S_ACCUM, S_DIVIDE, S_PUBLISH; reset state S_IDLE.
REQ-015 S_IDLE: beats without i_tuser discarded; fire with i_tuser clears sum_x(28b), sum_y(28b), count(19b), x=y=0, accumulates that beat, -> S_ACCUM.
REQ-016 S_ACCUM: each red fired beat adds x to sum_x, y to sum_y, 1 to count.
REQ-017 S_ACCUM fire with i_tuser (early SOF) SHALL discard partial sums and restart accumulation with that beat as pixel (0,0); no publish.
REQ-018 S_ACCUM fire at x==IMG_WIDTH-1, y==IMG_HEIGHT-1 SHALL end frame: count >= MIN_PIXELS -> S_DIVIDE, else -> S_PUBLISH with invalid result.
REQ-019 i_tlast not used for framing; i_tlast mismatch with x counter ignored.
REQ-020 S_DIVIDE: restoring divider, sum_x/count and sum_y/count in parallel, one quotient bit per cycle, exactly 28 cycles, -> S_PUBLISH; quotient truncated (floor), low 10/9 bits kept.
REQ-021 S_PUBLISH lasts one cycle: o_end_frame=1, outputs updated same cycle, -> S_IDLE.
REQ-022 Latency: final beat fired at edge k -> o_end_frame high cycle k+29 (valid) or k+1 (invalid).
REQ-023 o_centroid_x/y and o_red_object_valid SHALL hold stable between publishes.
REQ-024 Invalid publish: o_red_object_valid=0, centroid outputs 0.
REQ-025 o_tready=1 in S_IDLE and S_ACCUM, 0 in S_DIVIDE and S_PUBLISH.
REQ-026 i_tvalid gaps SHALL not affect accumulation.

Reset
REQ-027 i_rstn low SHALL immediately force S_IDLE, clear sums, counters, divider; o_tready=0 while low.
REQ-028 Output reset values: o_centroid_x=0, o_centroid_y=0, o_end_frame=0, o_red_object_valid=0.
REQ-029 Reset mid-frame or mid-divide SHALL discard the frame; no publish follows.

Configuration
REQ-030 Macro RED_CENTROID_HOLD_EN defined: invalid publish keeps previous centroid values (o_red_object_valid=0 still pulsed via o_end_frame).
REQ-031 Macro undefined: invalid publish zeroes centroid per REQ-024.

Verification
REQ-032 All-black frame (0x0000) -> o_end_frame at k+1, valid=0, centroid (0,0).
REQ-033 21x21 red (0xF800) square centred (100,50) -> centroid (100,50), valid=1, pulse at k+29.
REQ-034 Entire frame 0xF800 -> centroid (319,239), valid=1, o_tready low exactly 29 cycles.
REQ-035 MIN_PIXELS-1 red pixels -> valid=0; MIN_PIXELS red pixels -> valid=1.
REQ-036 SOF injected at row 200 after red square at (50,50), new frame with square at (400,300) -> single publish (400,300); random i_tvalid gaps give identical result.
REQ-037 Reset asserted during S_DIVIDE -> outputs 0 immediately, no o_end_frame pulse; next full frame publishes normally.
